// File: rtl/comb_mac4_if.sv
// Bundle between the feature/weight source and the comb_mac4 combination stage.
// No latency of its own; carries beat inputs and the per-vector lane results.
// No backpressure: valid_in qualifies beats and ready_out is a one-cycle strobe.
interface comb_mac4_if #(
  parameter int DATA_W = 8,
  parameter int K_LEN  = 16
);
  localparam int CNT_W = (K_LEN > 1) ? $clog2(K_LEN) : 1;

  logic                     clear;
  logic                     valid_in;
  logic signed [DATA_W-1:0] feat;
  logic signed [DATA_W-1:0] w0;
  logic signed [DATA_W-1:0] w1;
  logic signed [DATA_W-1:0] w2;
  logic signed [DATA_W-1:0] w3;
  logic signed [16:0]       out0;
  logic signed [16:0]       out1;
  logic signed [16:0]       out2;
  logic signed [16:0]       out3;
  logic                     ready_out;
  logic                     sat;
  logic [CNT_W-1:0]         beat_cnt;

  // Upstream side: drives beats, observes results
  modport master (
    output clear, valid_in, feat, w0, w1, w2, w3,
    input  out0, out1, out2, out3, ready_out, sat, beat_cnt
  );

  // Combination stage side
  modport slave (
    input  clear, valid_in, feat, w0, w1, w2, w3,
    output out0, out1, out2, out3, ready_out, sat, beat_cnt
  );
endinterface

// File: rtl/comb_mac4.sv
// 4-lane MAC: feat*w_i accumulated over K_LEN beats, then >>>SHIFT and clamped to s17.
// Latency: last beat sampled at edge n -> ready_out and new out0..3 after edge n+1.
// No backpressure; clear flushes the partial vector. Macro COMB_ROUND_EN: round half up before the shift.
module comb_mac4 #(
  parameter int DATA_W = 8,
  parameter int K_LEN  = 16,
  parameter int ACC_W  = 32,
  parameter int SHIFT  = 4
) (
  input  logic         clk,
  input  logic         rst,
  comb_mac4_if.slave   bus
);
  localparam int CNT_W = (K_LEN > 1) ? $clog2(K_LEN) : 1;
  localparam int PW    = 2 * DATA_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K_LEN - 1);
  // Half-LSB of the shifted result, added in ACC_W+1 bits so it cannot overflow
  localparam logic signed [ACC_W:0] RND_ADD =
    (SHIFT > 0) ? ((ACC_W + 1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W + 1)'(65535);
  localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W + 1)'(-65536);

  logic signed [DATA_W-1:0] w [4];
  assign w[0] = bus.w0;
  assign w[1] = bus.w1;
  assign w[2] = bus.w2;
  assign w[3] = bus.w3;

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    p_valid_q, p_valid_d;
  logic                    p_last_q, p_last_d;
  logic signed [PW-1:0]    prod_q [4];
  logic signed [PW-1:0]    prod_d [4];
  logic signed [ACC_W-1:0] acc_q [4];
  logic signed [ACC_W-1:0] acc_d [4];
  logic signed [ACC_W-1:0] sum [4];
  logic signed [ACC_W:0]   scaled [4];
  logic signed [16:0]      sat_val [4];
  logic [3:0]              clamp;
  logic signed [16:0]      out_q [4];
  logic signed [16:0]      out_d [4];
  logic                    ready_q, ready_d;
  logic                    sat_q, sat_d;

  // Per-lane running sum, scaling and clamp to the signed 17-bit range
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      sum[i] = acc_q[i] + ACC_W'(prod_q[i]);
`ifdef COMB_ROUND_EN
      scaled[i] = ($signed({sum[i][ACC_W-1], sum[i]}) + RND_ADD) >>> SHIFT;
`else
      scaled[i] = $signed({sum[i][ACC_W-1], sum[i]}) >>> SHIFT;
`endif
      clamp[i]   = 1'b0;
      sat_val[i] = scaled[i][16:0];
      if (scaled[i] > SAT_MAX) begin
        sat_val[i] = 17'h0FFFF;
        clamp[i]   = 1'b1;
      end else if (scaled[i] < SAT_MIN) begin
        sat_val[i] = 17'h10000;
        clamp[i]   = 1'b1;
      end
    end
  end

  // Next state: product stage, accumulate stage, end-of-vector output; clear wins over both
  always_comb begin
    cnt_d     = cnt_q;
    p_valid_d = 1'b0;
    p_last_d  = p_last_q;
    prod_d    = prod_q;
    acc_d     = acc_q;
    out_d     = out_q;
    ready_d   = 1'b0;
    sat_d     = sat_q;
    if (bus.clear) begin
      cnt_d = '0;
      for (int i = 0; i < 4; i++) acc_d[i] = '0;
    end else begin
      if (bus.valid_in) begin
        p_valid_d = 1'b1;
        p_last_d  = (cnt_q == CNT_LAST);
        cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        for (int i = 0; i < 4; i++) prod_d[i] = PW'(bus.feat) * PW'(w[i]);
      end
      if (p_valid_q) begin
        if (p_last_q) begin
          for (int i = 0; i < 4; i++) begin
            acc_d[i] = '0;
            out_d[i] = sat_val[i];
          end
          sat_d   = |clamp;
          ready_d = 1'b1;
        end else begin
          acc_d = sum;
        end
      end
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      p_valid_q <= 1'b0;
      p_last_q  <= 1'b0;
      ready_q   <= 1'b0;
      sat_q     <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        prod_q[i] <= '0;
        acc_q[i]  <= '0;
        out_q[i]  <= '0;
      end
    end else begin
      cnt_q     <= cnt_d;
      p_valid_q <= p_valid_d;
      p_last_q  <= p_last_d;
      ready_q   <= ready_d;
      sat_q     <= sat_d;
      prod_q    <= prod_d;
      acc_q     <= acc_d;
      out_q     <= out_d;
    end
  end

  assign bus.out0      = out_q[0];
  assign bus.out1      = out_q[1];
  assign bus.out2      = out_q[2];
  assign bus.out3      = out_q[3];
  assign bus.ready_out = ready_q;
  assign bus.sat       = sat_q;
  assign bus.beat_cnt  = cnt_q;
endmodule

// File: tb/tb_comb_mac4.sv
// Bench for comb_mac4: three instances (K4/S4, K8/S0, K1/S4) sharing feature/weight buses.
// Expected strobes are queued with their due cycle when the last beat is driven.
// Each strobe pops and compares lanes, sat and timing; stray strobes are flagged.
module tb_comb_mac4;
`ifdef COMB_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif

  typedef struct {
    int cyc;
    int o [4];
    int s;
  } exp_t;

  typedef struct {
    int d;
    int k;
    int gap;
    int f;
    int w [4];
    int e [4];
    int s;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic [2:0] vld_v;
  logic [2:0] clr_v;
  logic signed [7:0] feat_v, w0_v, w1_v, w2_v, w3_v;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  exp_t qa [$];
  exp_t qb [$];
  exp_t qc [$];
  vec_t tbl [8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  comb_mac4_if #(.DATA_W(8), .K_LEN(4)) ifa ();
  comb_mac4_if #(.DATA_W(8), .K_LEN(8)) ifb ();
  comb_mac4_if #(.DATA_W(8), .K_LEN(1)) ifc ();

  assign ifa.clear = clr_v[0];
  assign ifb.clear = clr_v[1];
  assign ifc.clear = clr_v[2];
  assign ifa.valid_in = vld_v[0];
  assign ifb.valid_in = vld_v[1];
  assign ifc.valid_in = vld_v[2];
  assign ifa.feat = feat_v;
  assign ifb.feat = feat_v;
  assign ifc.feat = feat_v;
  assign ifa.w0 = w0_v;
  assign ifa.w1 = w1_v;
  assign ifa.w2 = w2_v;
  assign ifa.w3 = w3_v;
  assign ifb.w0 = w0_v;
  assign ifb.w1 = w1_v;
  assign ifb.w2 = w2_v;
  assign ifb.w3 = w3_v;
  assign ifc.w0 = w0_v;
  assign ifc.w1 = w1_v;
  assign ifc.w2 = w2_v;
  assign ifc.w3 = w3_v;

  comb_mac4 #(.DATA_W(8), .K_LEN(4), .ACC_W(32), .SHIFT(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  comb_mac4 #(.DATA_W(8), .K_LEN(8), .ACC_W(32), .SHIFT(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  comb_mac4 #(.DATA_W(8), .K_LEN(1), .ACC_W(32), .SHIFT(4)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic on_strobe(input int d, input int o0, input int o1, input int o2, input int o3,
                           input int s);
    exp_t e;
    int n;
    case (d)
      0: n = qa.size();
      1: n = qb.size();
      default: n = qc.size();
    endcase
    if (n == 0) begin
      checks++;
      failures++;
      $display("FAIL strobe_d%0d unexpected strobe at cycle %0d, required none", d, cyc);
    end else begin
      case (d)
        0: e = qa.pop_front();
        1: e = qb.pop_front();
        default: e = qc.pop_front();
      endcase
      chk($sformatf("d%0d_strobe_cycle", d), cyc, e.cyc);
      chk($sformatf("d%0d_out0", d), o0, e.o[0]);
      chk($sformatf("d%0d_out1", d), o1, e.o[1]);
      chk($sformatf("d%0d_out2", d), o2, e.o[2]);
      chk($sformatf("d%0d_out3", d), o3, e.o[3]);
      chk($sformatf("d%0d_sat", d), s, e.s);
    end
  endtask

  always @(negedge clk) if (!rst && ifa.ready_out) on_strobe(0, ifa.out0, ifa.out1, ifa.out2, ifa.out3, int'(ifa.sat));
  always @(negedge clk) if (!rst && ifb.ready_out) on_strobe(1, ifb.out0, ifb.out1, ifb.out2, ifb.out3, int'(ifb.sat));
  always @(negedge clk) if (!rst && ifc.ready_out) on_strobe(2, ifc.out0, ifc.out1, ifc.out2, ifc.out3, int'(ifc.sat));

  // One beat on instance d; when push is set, queue the strobe due two edges later
  task automatic beat(input int d, input int f, input int a0, input int a1, input int a2,
                      input int a3, input bit push, input int e0, input int e1, input int e2,
                      input int e3, input int s);
    exp_t e;
    feat_v = 8'(f);
    w0_v = 8'(a0);
    w1_v = 8'(a1);
    w2_v = 8'(a2);
    w3_v = 8'(a3);
    vld_v[d] = 1'b1;
    if (push) begin
      e.cyc = cyc + 2;
      e.o[0] = e0;
      e.o[1] = e1;
      e.o[2] = e2;
      e.o[3] = e3;
      e.s = s;
      case (d)
        0: qa.push_back(e);
        1: qb.push_back(e);
        default: qc.push_back(e);
      endcase
    end
    @(negedge clk);
    vld_v[d] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{d: 0, k: 4, gap: 1, f: 16,  w: '{1, 2, -3, 0},       e: '{4, 8, -12, 0},             s: 0};
    tbl[1] = '{d: 0, k: 4, gap: 0, f: -8,  w: '{5, -9, 127, -128},  e: '{-10, 18, -254, 256},       s: 0};
    tbl[2] = '{d: 0, k: 4, gap: 0, f: 127, w: '{127, 127, -128, -128}, e: '{4032, 4032, -4064, -4064}, s: 0};
    tbl[3] = '{d: 1, k: 8, gap: 0, f: 127, w: '{127, -127, 1, 0},   e: '{65535, -65536, 1016, 0},   s: 1};
    tbl[4] = '{d: 1, k: 8, gap: 0, f: -3,  w: '{2, 0, 0, 0},        e: '{-48, 0, 0, 0},             s: 0};
    tbl[5] = '{d: 2, k: 1, gap: 0, f: 4,   w: '{6, 0, 0, 0},        e: '{RND ? 2 : 1, 0, 0, 0},     s: 0};
    tbl[6] = '{d: 2, k: 1, gap: 0, f: 4,   w: '{-6, 0, 0, 0},       e: '{RND ? -1 : -2, 0, 0, 0},   s: 0};
    tbl[7] = '{d: 2, k: 1, gap: 0, f: 100, w: '{127, -128, 0, 0},   e: '{RND ? 794 : 793, -800, 0, 0}, s: 0};

    rst = 1'b1;
    vld_v = '0;
    clr_v = '0;
    feat_v = '0;
    w0_v = '0;
    w1_v = '0;
    w2_v = '0;
    w3_v = '0;
    idle(2);
    chk("rst_a_out0", ifa.out0, 0);
    chk("rst_a_ready", int'(ifa.ready_out), 0);
    chk("rst_a_sat", int'(ifa.sat), 0);
    chk("rst_a_beat_cnt", int'(ifa.beat_cnt), 0);
    chk("rst_b_out1", ifb.out1, 0);
    chk("rst_c_out0", ifc.out0, 0);
    chk("rst_c_beat_cnt", int'(ifc.beat_cnt), 0);
    rst = 1'b0;
    idle(1);

    // Table: gapped vector, back-to-back vectors, saturation, K_LEN=1 rounding stream
    for (int t = 0; t < 8; t++) begin
      for (int b = 0; b < tbl[t].k; b++) begin
        beat(tbl[t].d, tbl[t].f, tbl[t].w[0], tbl[t].w[1], tbl[t].w[2], tbl[t].w[3],
             b == tbl[t].k - 1, tbl[t].e[0], tbl[t].e[1], tbl[t].e[2], tbl[t].e[3], tbl[t].s);
        if (tbl[t].gap != 0) idle(1);
      end
    end
    idle(4);
    chk("table_qa_drained", qa.size(), 0);
    chk("table_qb_drained", qb.size(), 0);
    chk("table_qc_drained", qc.size(), 0);

    // clear mid-vector: partial beats and a same-cycle beat are discarded
    beat(0, 16, 1, 0, 0, 0, 1'b0, 0, 0, 0, 0, 0);
    beat(0, 16, 1, 0, 0, 0, 1'b0, 0, 0, 0, 0, 0);
    chk("clr_beat_cnt_before", int'(ifa.beat_cnt), 2);
    clr_v[0] = 1'b1;
    vld_v[0] = 1'b1;
    feat_v = 8'sd50;
    idle(1);
    clr_v[0] = 1'b0;
    vld_v[0] = 1'b0;
    chk("clr_beat_cnt_after", int'(ifa.beat_cnt), 0);
    chk("clr_out0_held", ifa.out0, 4032);
    chk("clr_ready_low", int'(ifa.ready_out), 0);

    // clear right after the last beat drops the in-flight vector (no strobe)
    for (int b = 0; b < 4; b++) beat(0, 16, 1, 0, 0, 0, 1'b0, 0, 0, 0, 0, 0);
    clr_v[0] = 1'b1;
    idle(1);
    clr_v[0] = 1'b0;
    idle(2);
    chk("drop_out0_held", ifa.out0, 4032);
    chk("drop_out3_held", ifa.out3, -4064);

    // fresh vector after clear
    for (int b = 0; b < 3; b++) beat(0, 16, 1, 0, 0, 0, 1'b0, 0, 0, 0, 0, 0);
    chk("fresh_out0_held", ifa.out0, 4032);
    beat(0, 16, 1, 0, 0, 0, 1'b1, 4, 0, 0, 0, 0);
    idle(3);
    chk("clr_qa_drained", qa.size(), 0);

    // asynchronous reset between edges after beat 3
    for (int b = 0; b < 3; b++) beat(0, 16, 1, 2, -3, 0, 1'b0, 0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_a_out0", ifa.out0, 0);
    chk("arst_a_beat_cnt", int'(ifa.beat_cnt), 0);
    chk("arst_a_ready", int'(ifa.ready_out), 0);
    chk("arst_b_out0", ifb.out0, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    for (int b = 0; b < 4; b++) beat(0, 16, 1, 2, -3, 0, b == 3, 4, 8, -12, 0, 0);
    idle(3);
    chk("arst_qa_drained", qa.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
